// File: rtl/spi_word_sequencer_if.sv
// Host-side table/control bundle for spi_word_sequencer.
// Ports: wr_*, rd_*, start/num_words in; busy/done/word_idx/rd_data out.
interface spi_word_sequencer_if #(
  parameter int WORD_BITS = 64,
  parameter int CW        = 4
) ();
  logic                 wr_en;
  logic [CW-1:0]        wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic [CW-1:0]        rd_addr;
  logic [WORD_BITS-1:0] rd_data;
  logic                 start;
  logic [CW-1:0]        num_words;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        word_idx;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr, start, num_words,
    input  rd_data, busy, done, word_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, start, num_words,
    output rd_data, busy, done, word_idx
  );
endinterface

// File: rtl/spi_word_sequencer.sv
// Mode-0 SPI master streaming a word table (bytes LSB-first, bits MSB-first).
// Ports: CLK, resetn (sync low), bus (slave modport), SCK/CS/COPI out, CIPO in.
// Macro SPI_READBACK_EN adds the CIPO capture table behind rd_addr/rd_data.
module spi_word_sequencer #(
  parameter int WORD_BITS = 64,
  parameter int NUM_WORDS = 8,
  parameter int CLK_DIV   = 4,
  parameter int CW        = $clog2(NUM_WORDS+1)
) (
  input  logic                CLK,
  input  logic                resetn,
  spi_word_sequencer_if.slave bus,
  output logic                SCK,
  output logic                CS,
  output logic                COPI,
  input  logic                CIPO
);
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BW = $clog2(WORD_BITS);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] NW_MAX = CW'(NUM_WORDS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV/2-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS-1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [CW-1:0]        nwords;
  logic [CW-1:0]        widx;
  logic [WORD_BITS-1:0] cur;
  logic                 busy_q;
  logic                 done_q;

  logic [WORD_BITS-1:0] tx_mem [2**AW];

  logic [BW-1:0] nxt_pos;
  logic [AW-1:0] nxt_idx;
  logic [CW-1:0] nw_clamp;
  logic          word_end;

  // Byte-LSB-first, bit-MSB-first: bit k of the stream is word bit k^7.
  assign nxt_pos  = (bit_cnt + BW'(1)) ^ BW'(7);
  assign nxt_idx  = widx[AW-1:0] + AW'(1);
  assign nw_clamp = (bus.num_words > NW_MAX) ? NW_MAX : bus.num_words;
  assign word_end = (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.word_idx = widx;

  always_ff @(posedge CLK) begin
    if (bus.wr_en && state != SHIFT && bus.wr_addr < NW_MAX)
      tx_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state   <= IDLE;
      SCK     <= 1'b0;
      CS      <= 1'b1;
      COPI    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      widx    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      nwords  <= '0;
      cur     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_words == '0) begin
              state  <= FINISH;
              done_q <= 1'b1;
            end else begin
              state   <= SHIFT;
              CS      <= 1'b0;
              busy_q  <= 1'b1;
              widx    <= '0;
              div_cnt <= '0;
              bit_cnt <= '0;
              nwords  <= nw_clamp;
              cur     <= tx_mem[0];
              COPI    <= tx_mem[0][7];
            end
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCK     <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (widx == nwords - CW'(1)) begin
                state  <= FINISH;
                CS     <= 1'b1;
                COPI   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                widx <= widx + CW'(1);
                cur  <= tx_mem[nxt_idx];
                COPI <= tx_mem[nxt_idx][7];
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              COPI    <= cur[nxt_pos];
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
            SCK     <= (div_cnt >= DIV_RISE);
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV/2);

  logic [WORD_BITS-1:0] rx_mem [2**AW];
  logic [WORD_BITS-1:0] rx_sh;
  logic [WORD_BITS-1:0] rx_word;
  logic [WORD_BITS-1:0] rd_q;
  logic [BW-1:0]        pos;

  assign pos = bit_cnt ^ BW'(7);
  assign bus.rd_data = rd_q;

  // Merge the bit sampled this edge so CLK_DIV==2 still commits it.
  always_comb begin
    rx_word = rx_sh;
    if (div_cnt == DIV_HALF)
      rx_word[pos] = CIPO;
  end

  always_ff @(posedge CLK) begin
    if (resetn && state == SHIFT) begin
      if (div_cnt == DIV_HALF)
        rx_sh <= rx_word;
      if (word_end)
        rx_mem[widx[AW-1:0]] <= rx_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn)
      rd_q <= '0;
    else if (bus.rd_addr < NW_MAX)
      rd_q <= rx_mem[bus.rd_addr[AW-1:0]];
    else
      rd_q <= '0;
  end
`else
  logic unused_rx;
  assign unused_rx   = ^{bus.rd_addr, CIPO, word_end};
  assign bus.rd_data = '0;
`endif
endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer: per-cycle capture vs. a serial stream model.
// Ports driven through spi_word_sequencer_if; CIPO looped back from COPI.
`timescale 1ns/1ps
module tb_spi_word_sequencer;
  localparam int WB  = 64;
  localparam int NW  = 8;
  localparam int DIV = 4;
  localparam int CW  = $clog2(NW+1);
  localparam int WC  = WB*DIV;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  logic SCK, CS, COPI, CIPO;

  spi_word_sequencer_if #(.WORD_BITS(WB), .CW(CW)) bus ();

  spi_word_sequencer #(
    .WORD_BITS(WB), .NUM_WORDS(NW), .CLK_DIV(DIV), .CW(CW)
  ) dut (
    .CLK(CLK), .resetn(resetn), .bus(bus),
    .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO)
  );

  assign CIPO = COPI;
  always #5 CLK = ~CLK;

  logic [WB-1:0] tx_model [NW];
  int n_cmp = 0;
  int n_bad = 0;
  int r, d, n;
  logic prev;

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [WB-1:0] obs,
                       input logic [WB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // n-th bit on the wire: word n/WB, byte ascending, bit 7 first.
  function automatic logic exp_bit(input int idx);
    int w, k;
    logic [WB-1:0] word;
    w = idx / WB;
    k = idx % WB;
    word = tx_model[w];
    return word[(k/8)*8 + 7 - (k%8)];
  endfunction

  task automatic wr(input int a, input logic [WB-1:0] dat);
    bus.wr_en = 1'b1;
    bus.wr_addr = CW'(a);
    bus.wr_data = dat;
    @(negedge CLK);
    bus.wr_en = 1'b0;
    if (a < NW) tx_model[a] = dat;
  endtask

  task automatic rd_chk(input int a, input logic [WB-1:0] exp,
                        input string tag);
    bus.rd_addr = CW'(a);
    @(negedge CLK);
    chk_w(tag, bus.rd_data, exp);
  endtask

  task automatic run_txn(input int nw, input int inj, input string tag);
    int eff, cs_low, busy_n, rises, dones, first_low, last_low;
    int first_rise, done_at, badbits, badidx, tail, span;
    logic pv;
    eff = (nw > NW) ? NW : nw;
    cs_low = 0; busy_n = 0; rises = 0; dones = 0;
    first_low = -1; last_low = -1; first_rise = -1; done_at = -1;
    badbits = 0; badidx = 0; tail = 0; pv = 1'b0;
    bus.start = 1'b1;
    bus.num_words = CW'(nw);
    @(negedge CLK);
    bus.start = 1'b0;
    bus.num_words = CW'($urandom_range(0, 2**CW-1));
    for (int c = 0; c < eff*WC + 16 && tail < 3; c++) begin
      if (CS === 1'b0) begin
        cs_low++;
        if (first_low < 0) first_low = c;
        last_low = c;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (SCK === 1'b1 && pv === 1'b0) begin
        if (first_rise < 0) first_rise = c;
        if (rises >= eff*WB) badbits++;
        else if (COPI !== exp_bit(rises)) badbits++;
        if (bus.word_idx !== CW'(rises / WB)) badidx++;
        rises++;
      end
      if (bus.done === 1'b1) begin
        dones++;
        done_at = c;
      end
      if (dones > 0) tail++;
      pv = SCK;
      if (c == inj) begin
        bus.start = 1'b1;
        bus.num_words = CW'(1);
        bus.wr_en = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = ~tx_model[0];
      end else begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      @(negedge CLK);
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    span = (first_low < 0) ? 0 : last_low - first_low + 1;
    chk_i({tag, ".cs_low"}, cs_low, eff*WC);
    chk_i({tag, ".cs_span"}, span, eff*WC);
    chk_i({tag, ".cs_first"}, first_low, (eff > 0) ? 0 : -1);
    chk_i({tag, ".busy"}, busy_n, eff*WC);
    chk_i({tag, ".rises"}, rises, eff*WB);
    chk_i({tag, ".first_rise"}, first_rise, (eff > 0) ? DIV/2 : -1);
    chk_i({tag, ".bits"}, badbits, 0);
    chk_i({tag, ".word_idx"}, badidx, 0);
    chk_i({tag, ".dones"}, dones, 1);
    chk_i({tag, ".done_at"}, done_at, eff*WC);
`ifdef SPI_READBACK_EN
    for (int w = 0; w < eff; w++)
      rd_chk(w, tx_model[w], {tag, ".rx"});
`else
    rd_chk(0, '0, {tag, ".rd_zero"});
`endif
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    bus.start = 1'b0;
    bus.num_words = '0;
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    chk_i("rst.sck", int'(SCK), 0);
    chk_i("rst.cs", int'(CS), 1);
    chk_i("rst.copi", int'(COPI), 0);
    chk_i("rst.busy", int'(bus.busy), 0);
    chk_i("rst.done", int'(bus.done), 0);
    chk_i("rst.word_idx", int'(bus.word_idx), 0);
    chk_w("rst.rd_data", bus.rd_data, '0);
    resetn = 1'b1;
    @(negedge CLK);

    wr(0, 64'h0a00000000000001);
    run_txn(1, -1, "one");

    wr(0, {$urandom, $urandom});
    wr(1, 64'h00000000005fffff);
    wr(2, {$urandom, $urandom});
    run_txn(3, -1, "three");

    run_txn(0, -1, "zero");

    for (int w = 0; w < NW; w++) wr(w, {$urandom, $urandom});
    wr(NW, {$urandom, $urandom});
    run_txn(15, -1, "clamp");

    // Reset while word 0 bit 20 is on the wire.
    bus.start = 1'b1;
    bus.num_words = CW'(1);
    @(negedge CLK);
    bus.start = 1'b0;
    r = 0;
    prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (SCK === 1'b1 && prev === 1'b0) r++;
      prev = SCK;
      if (r == 21) break;
      @(negedge CLK);
    end
    chk_i("abort.reach", r, 21);
    resetn = 1'b0;
    @(negedge CLK);
    chk_i("abort.cs", int'(CS), 1);
    chk_i("abort.sck", int'(SCK), 0);
    chk_i("abort.busy", int'(bus.busy), 0);
    d = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done !== 1'b0) d++;
      @(negedge CLK);
    end
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus.done !== 1'b0 || CS !== 1'b1) d++;
      @(negedge CLK);
    end
    chk_i("abort.no_done", d, 0);
    run_txn(1, -1, "after_abort");

    run_txn(2, 300, "mid_inject");
    run_txn(1, -1, "tx0_kept");

    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 3);
      for (int w = 0; w < n; w++) wr(w, {$urandom, $urandom});
      run_txn(n, -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
